// File: rtl/reg_writeback_queue.sv
// Register write-back queue.
// A small circular FIFO that buffers (dest, data) register writes until the
// register-file write port is free. Queued writes are visible to decode
// through two forwarding ports, so a reader always sees the youngest pending
// value. Writes to register 0 complete the handshake but are dropped.
module reg_writeback_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDRESS_WIDTH-1:0]   wb_dest,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic                       drain_en,
    output logic                       rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]      rg_wrt_data,
    input  logic [ADDRESS_WIDTH-1:0]   rg_rd_addr1,
    input  logic [ADDRESS_WIDTH-1:0]   rg_rd_addr2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DATA_WIDTH-1:0]      fwd_data1,
    output logic [DATA_WIDTH-1:0]      fwd_data2,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            push;
    logic            pop;
    logic            not_empty;

    // Read ports grouped so both lookups share one search loop.
    logic [1:0][ADDRESS_WIDTH-1:0] rd_addr;
    logic [1:0]                    hit;
    logic [1:0][DATA_WIDTH-1:0]    fdata;

    // Ready depends only on registered occupancy: a pop this cycle does not
    // open a slot until the next cycle, keeping ready free of drain_en.
    assign not_empty = (occupancy != '0);
    assign wb_ready  = ~rst & (occupancy < FULL);
    assign push      = wb_valid & wb_ready & (wb_dest != '0);
    assign rg_wrt_en = not_empty & drain_en & ~rst;
    assign pop       = rg_wrt_en;

    assign rg_wrt_dest = not_empty ? mem[head].dest : '0;
    assign rg_wrt_data = not_empty ? mem[head].data : '0;

    assign rd_addr[0] = rg_rd_addr1;
    assign rd_addr[1] = rg_rd_addr2;
    assign fwd_hit1   = hit[0];
    assign fwd_hit2   = hit[1];
    assign fwd_data1  = fdata[0];
    assign fwd_data2  = fdata[1];

    // Forwarding search: walk valid entries oldest to youngest so the last
    // match wins; the head being popped this cycle is still searched.
    always_comb begin
        logic [PW-1:0] idx;
        hit   = '0;
        fdata = '0;
        idx   = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (!rst && (CW'(i) < occupancy) && (rd_addr[p] != '0) &&
                    (mem[idx].dest == rd_addr[p])) begin
                    hit[p]   = 1'b1;
                    fdata[p] = mem[idx].data;
                end
            end
        end
    end

    // Entry storage: written on push only, contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[tail] <= '{dest: wb_dest, data: wb_data};
        end
    end

    // Pointers and occupancy; reset drops everything, including any
    // handshake that happens to be in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized and directed bench for reg_writeback_queue with a queue model.
module tb_reg_writeback_queue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic          drain_en;
    logic          rg_wrt_en;
    logic [AW-1:0] rg_wrt_dest;
    logic [DW-1:0] rg_wrt_data;
    logic [AW-1:0] rg_rd_addr1;
    logic [AW-1:0] rg_rd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [$clog2(DEPTH):0] occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [AW-1:0] dest; logic [DW-1:0] data; } wr_t;
    wr_t q[$];

    reg_writeback_queue #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
        .drain_en(drain_en),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Apply inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] dt,
                         input logic dr, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        wb_valid = v; wb_dest = d; wb_data = dt; drain_en = dr;
        rg_rd_addr1 = a1; rg_rd_addr2 = a2;
        #1;
    endtask

    // Advance one clock and update the model from the rules: a write leaves
    // when the port is free, an offer is taken while fewer than DEPTH are held.
    task automatic tick();
        bit do_push, do_pop;
        wr_t e;
        do_pop  = !rst && q.size() != 0 && drain_en;
        do_push = !rst && wb_valid && q.size() < DEPTH && wb_dest != 0;
        e.dest = wb_dest; e.data = wb_data;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    // Youngest queued write to addr, if any.
    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] addr);
        if (rst || addr == 0) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].dest == addr) return {1'b1, q[i].data};
        return '0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 32'h1234, 1, 5, 5);
        checks++;
        if (wb_ready !== 1'b0 || rg_wrt_en !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b wen=%b hit1=%b hit2=%b, required all 0",
                     wb_ready, rg_wrt_en, fwd_hit1, fwd_hit2);
        end
        tick(); tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (occupancy !== 0 || wb_ready !== 1'b1 || rg_wrt_en !== 1'b0 ||
            rg_wrt_dest !== 0 || rg_wrt_data !== 0 || fwd_data1 !== 0 || fwd_data2 !== 0) begin
            errors++;
            $display("FAIL reset_after: occ=%0d ready=%b wen=%b dest=%0d data=%h, required 0 1 0 0 0",
                     occupancy, wb_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 5, 32'hDEADBEEF, 1, 0, 0);
        checks++;
        if (wb_ready !== 1'b1 || rg_wrt_en !== 1'b0) begin
            errors++;
            $display("FAIL single_offer: ready=%b wen=%b, required 1 0", wb_ready, rg_wrt_en);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5 || rg_wrt_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: wen=%b dest=%0d data=%h, required 1 5 deadbeef",
                     rg_wrt_en, rg_wrt_dest, rg_wrt_data);
        end
        tick();
        checks++;
        if (occupancy !== 0 || rg_wrt_en !== 1'b0) begin
            errors++;
            $display("FAIL single_drained: occ=%0d wen=%b, required 0 0", occupancy, rg_wrt_en);
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1, AW'(k), DW'(k * 16), 0, 0, 0);
            tick();
        end
        drive(1, 5, 32'h50, 0, 0, 0);
        checks++;
        if (occupancy !== 4 || wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: occ=%0d ready=%b, required 4 0", occupancy, wb_ready);
        end
        tick();
        drive(1, 5, 32'h50, 1, 0, 0);
        checks++;
        if (occupancy !== 4 || wb_ready !== 1'b0 || rg_wrt_en !== 1'b1 || rg_wrt_dest !== 1) begin
            errors++;
            $display("FAIL fill_first_pop: occ=%0d ready=%b wen=%b dest=%0d, required 4 0 1 1",
                     occupancy, wb_ready, rg_wrt_en, rg_wrt_dest);
        end
        tick();
        checks++;
        if (wb_ready !== 1'b1 || occupancy !== 3 || rg_wrt_dest !== 2) begin
            errors++;
            $display("FAIL fill_ready_back: ready=%b occ=%0d dest=%0d, required 1 3 2",
                     wb_ready, occupancy, rg_wrt_dest);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 3; k <= 5; k++) begin
            checks++;
            if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== AW'(k) || rg_wrt_data !== DW'(k * 16)) begin
                errors++;
                $display("FAIL fill_order: wen=%b dest=%0d data=%h, required 1 %0d %h",
                         rg_wrt_en, rg_wrt_dest, rg_wrt_data, k, k * 16);
            end
            tick();
        end
        checks++;
        if (occupancy !== 0) begin
            errors++;
            $display("FAIL fill_empty: occ=%0d, required 0", occupancy);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(1, 7, 32'h11, 0, 0, 0); tick();
        drive(1, 7, 32'h22, 0, 0, 0); tick();
        drive(1, 8, 32'h33, 0, 7, 8);
        checks++;
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
            errors++;
            $display("FAIL fwd_youngest: hit=%b data=%h, required 1 22", fwd_hit1, fwd_data1);
        end
        checks++;
        if (fwd_hit2 !== 1'b0 || fwd_data2 !== 0) begin
            errors++;
            $display("FAIL fwd_miss_offer: hit=%b data=%h, required 0 0", fwd_hit2, fwd_data2);
        end
        drive(0, 0, 0, 1, 7, 7); tick();
        // Only (7,0x22) left and it is being popped now; it must still forward.
        drive(0, 0, 0, 1, 7, 0);
        checks++;
        if (rg_wrt_en !== 1'b1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22 || fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL fwd_head_pop: wen=%b hit1=%b data1=%h hit2=%b, required 1 1 22 0",
                     rg_wrt_en, fwd_hit1, fwd_data1, fwd_hit2);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 0);
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: ready=%b, required 1", wb_ready);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (occupancy !== 0 || rg_wrt_en !== 1'b0 || fwd_hit1 !== 1'b0) begin
            errors++;
            $display("FAIL x0_dropped: occ=%0d wen=%b hit1=%b, required 0 0 0",
                     occupancy, rg_wrt_en, fwd_hit1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] dat [10];
        do_reset();
        for (int k = 0; k < 10; k++) dat[k] = $urandom;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive(1, AW'(k + 1), dat[k], 1, 0, 0);
            else        drive(0, 0, 0, 1, 0, 0);
            checks++;
            if (k == 0) begin
                if (rg_wrt_en !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first: wen=%b, required 0", rg_wrt_en);
                end
            end else if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== AW'(k) || rg_wrt_data !== dat[k-1]) begin
                errors++;
                $display("FAIL b2b_order: step %0d wen=%b dest=%0d data=%h, required 1 %0d %h",
                         k, rg_wrt_en, rg_wrt_dest, rg_wrt_data, k, dat[k-1]);
            end
            tick();
            checks++;
            if (occupancy > 1) begin
                errors++;
                $display("FAIL b2b_occ: step %0d occ=%0d, required <=1", k, occupancy);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1, AW'(k + 10), DW'(k), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 11, 12);
        checks++;
        if (occupancy !== 3) begin
            errors++;
            $display("FAIL rmid_occ: occ=%0d, required 3", occupancy);
        end
        rst = 1'b1;
        drive(1, 20, 32'h99, 1, 11, 12);
        checks++;
        if (wb_ready !== 1'b0 || rg_wrt_en !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_during: ready=%b wen=%b hit1=%b hit2=%b, required 0 0 0 0",
                     wb_ready, rg_wrt_en, fwd_hit1, fwd_hit2);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 11, 12);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (occupancy !== 0 || rg_wrt_en !== 1'b0 || rg_wrt_dest !== 0 ||
                rg_wrt_data !== 0 || fwd_hit1 !== 1'b0) begin
                errors++;
                $display("FAIL rmid_after: cyc %0d occ=%0d wen=%b dest=%0d hit1=%b, required 0 0 0 0",
                         k, occupancy, rg_wrt_en, rg_wrt_dest, fwd_hit1);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [DW:0] f1, f2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            f1 = model_fwd(rg_rd_addr1);
            f2 = model_fwd(rg_rd_addr2);
            checks++;
            if (occupancy !== q.size() ||
                wb_ready !== (!rst && q.size() < DEPTH) ||
                rg_wrt_en !== (!rst && q.size() != 0 && drain_en)) begin
                errors++;
                $display("FAIL rnd_ctrl: cyc %0d occ=%0d ready=%b wen=%b, required %0d %b %b", n,
                         occupancy, wb_ready, rg_wrt_en, q.size(),
                         !rst && q.size() < DEPTH, !rst && q.size() != 0 && drain_en);
            end
            checks++;
            if (q.size() != 0 && (rg_wrt_dest !== q[0].dest || rg_wrt_data !== q[0].data)) begin
                errors++;
                $display("FAIL rnd_head: cyc %0d dest=%0d data=%h, required %0d %h",
                         n, rg_wrt_dest, rg_wrt_data, q[0].dest, q[0].data);
            end else if (q.size() == 0 && (rg_wrt_dest !== 0 || rg_wrt_data !== 0)) begin
                errors++;
                $display("FAIL rnd_head_empty: cyc %0d dest=%0d data=%h, required 0 0",
                         n, rg_wrt_dest, rg_wrt_data);
            end
            checks++;
            if ({fwd_hit1, fwd_data1} !== f1 || {fwd_hit2, fwd_data2} !== f2) begin
                errors++;
                $display("FAIL rnd_fwd: cyc %0d got %b/%h %b/%h, required %b/%h %b/%h", n,
                         fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, f1[DW], f1[DW-1:0], f2[DW], f2[DW-1:0]);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_fill_stall();
        test_forwarding();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
